vga_axil_regs: RTL and testbench

- AXI4-Lite slave register file for the VGA core; connects to the slave side of the vga_axil_if bus and consumes the read/write transactions issued by the bus master.
- Holds the control and colour registers that drive the VGA timing/pixel stage, and exposes a read-only status word containing a free-running frame counter.
- One outstanding read and one outstanding write; read and write paths are independent.

---
 rtl/vga_axil_regs.sv | 271 +++++++++++++++++++++++++++
 tb/tb_vga_axil_regs.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_axil_regs.sv
// AXI4-Lite register file for the VGA core: CTRL/FG/BG colour registers and a
// read-only STATUS word holding a free-running frame counter.
module vga_axil_regs #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FCNT_W = 16
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic                frame_done_i,
    output logic                ctrl_en_o,
    output logic [1:0]          ctrl_mode_o,
    output logic [11:0]         fg_color_o,
    output logic [11:0]         bg_color_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_HAVE_AW = 2'd1, W_HAVE_W = 2'd2, W_RESP = 2'd3} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;

    wr_state_t           wr_state_q, wr_state_d;
    rd_state_t           rd_state_q, rd_state_d;
    logic                awready_q, awready_d, wready_q, wready_d;
    logic                bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [11:0]         wdata_q, wdata_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic [11:0]         fg_q, fg_d, bg_q, bg_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [11:0]         wr_data_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                unused_ok_s;

    // Address lies in the 16-byte register window and is word aligned.
    function automatic logic addr_in_map(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr[ADDR_W-1:4] == '0);
    endfunction

    assign aw_hs_s = awvalid & awready_q;
    assign w_hs_s  = wvalid & wready_q;
    assign ar_hs_s = arvalid & arready_q;

    // Partial strobes are treated as full-word writes; upper data bits have no storage.
    assign unused_ok_s = ^{wstrb, wdata[DATA_W-1:12]};

    assign wr_addr_s = (wr_state_q == W_HAVE_AW) ? awaddr_q : awaddr;
    assign wr_data_s = (wr_state_q == W_HAVE_W) ? wdata_q : wdata[11:0];

    // Write channel FSM and register update at commit.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        ctrl_d     = ctrl_q;
        fg_d       = fg_q;
        bg_d       = bg_q;
        commit_s   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                wready_d  = 1'b1;
                if (aw_hs_s && w_hs_s) begin
                    commit_s = 1'b1;
                end else if (aw_hs_s) begin
                    wr_state_d = W_HAVE_AW;
                    awaddr_d   = awaddr;
                    awready_d  = 1'b0;
                end else if (w_hs_s) begin
                    wr_state_d = W_HAVE_W;
                    wdata_d    = wdata[11:0];
                    wready_d   = 1'b0;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                if (w_hs_s) commit_s = 1'b1;
                else        wr_state_d = W_HAVE_AW;
            end
            W_HAVE_W: begin
                if (aw_hs_s) commit_s = 1'b1;
                else         wr_state_d = W_HAVE_W;
            end
            W_RESP: begin
                if (bready) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                awready_d  = 1'b0;
                wready_d   = 1'b0;
                bvalid_d   = 1'b0;
                bresp_d    = RESP_OKAY;
            end
        endcase
        if (commit_s) begin
            wr_state_d = W_RESP;
            awready_d  = 1'b0;
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            if (addr_in_map(wr_addr_s) && (wr_addr_s[3:2] != 2'd3)) begin
                bresp_d = RESP_OKAY;
                case (wr_addr_s[3:2])
                    2'd0:    ctrl_d = wr_data_s[2:0];
                    2'd1:    fg_d   = wr_data_s;
                    2'd2:    bg_d   = wr_data_s;
                    default: ctrl_d = ctrl_q;
                endcase
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else begin
            commit_s = 1'b0;
        end
    end

    // Read decode; STATUS samples the counter before any same-cycle increment.
    always_comb begin
        rd_word_s = '0;
        case (araddr[3:2])
            2'd0:    rd_word_s = {{(DATA_W-3){1'b0}}, ctrl_q};
            2'd1:    rd_word_s = {{(DATA_W-12){1'b0}}, fg_q};
            2'd2:    rd_word_s = {{(DATA_W-12){1'b0}}, bg_q};
            2'd3:    rd_word_s = {{(DATA_W-FCNT_W){1'b0}}, fcnt_q};
            default: rd_word_s = '0;
        endcase
    end

    // Read channel FSM.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs_s) begin
                    rd_state_d = R_RESP;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    if (addr_in_map(araddr)) begin
                        rdata_d = rd_word_s;
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rd_state_d = R_IDLE;
                    arready_d  = 1'b1;
                    rvalid_d   = 1'b0;
                    rdata_d    = '0;
                    rresp_d    = RESP_OKAY;
                end else begin
                    rd_state_d = R_RESP;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                arready_d  = 1'b0;
                rvalid_d   = 1'b0;
            end
        endcase
    end

    // Frame counter wraps naturally at 2^FCNT_W.
    always_comb begin
        if (frame_done_i) fcnt_d = fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
        else              fcnt_d = fcnt_q;
    end

    // Write path and register-file state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            awaddr_q   <= '0;
            wdata_q    <= 12'h000;
            ctrl_q     <= 3'b000;
            fg_q       <= 12'h000;
            bg_q       <= 12'h000;
            fcnt_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            ctrl_q     <= ctrl_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Read path state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign awready     = awready_q;
    assign wready      = wready_q;
    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;
    assign arready     = arready_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign ctrl_en_o   = ctrl_q[0];
    assign ctrl_mode_o = ctrl_q[2:1];
    assign fg_color_o  = fg_q;
    assign bg_color_o  = bg_q;
endmodule

// File: tb/tb_vga_axil_regs.sv
// Directed self-checking bench for vga_axil_regs: inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_vga_axil_regs;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready, frame_done_i;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ctrl_en_o;
    logic [1:0]  ctrl_mode_o;
    logic [11:0] fg_color_o, bg_color_o;

    int n_cmp = 0;
    int n_bad = 0;

    vga_axil_regs #(.ADDR_W(32), .DATA_W(32), .FCNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .frame_done_i(frame_done_i),
        .ctrl_en_o(ctrl_en_o), .ctrl_mode_o(ctrl_mode_o),
        .fg_color_o(fg_color_o), .bg_color_o(bg_color_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] exp_resp, input string tag);
        bit aw_ok, w_ok;
        int n;
        aw_ok = 0; w_ok = 0; n = 0;
        awaddr = addr; wdata = data; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            @(negedge clk);
            n++;
            if (aw_ok) awvalid = 1'b0;
            if (w_ok) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check_val({tag, ".handshake"}, 32'(n < 20), 32'd1);
        check_val({tag, ".bvalid"}, 32'(bvalid), 32'd1);
        check_val({tag, ".bresp"}, 32'(bresp), 32'(exp_resp));
        @(negedge clk);
        check_val({tag, ".bvalid_drop"}, 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        int n;
        n = 0;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        check_val({tag, ".handshake"}, 32'(n < 20), 32'd1);
        check_val({tag, ".rvalid"}, 32'(rvalid), 32'd1);
        check_val({tag, ".rdata"}, rdata, exp_data);
        check_val({tag, ".rresp"}, 32'(rresp), 32'(exp_resp));
        @(negedge clk);
        check_val({tag, ".rvalid_drop"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        arst_n = 1'b0;
        awaddr = 32'h0; wdata = 32'h0; araddr = 32'h0; wstrb = 4'h0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; frame_done_i = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.arready", 32'(arready), 32'd0);
        check_val("rst.bvalid", 32'(bvalid), 32'd0);
        check_val("rst.fg", 32'(fg_color_o), 32'h0);
        arst_n = 1'b1;
        check_val("rel.arready0", 32'(arready), 32'd0);
        @(negedge clk);
        check_val("rel.arready1", 32'(arready), 32'd1);
        check_val("rel.awready1", 32'(awready), 32'd1);
        check_val("rel.wready1", 32'(wready), 32'd1);

        do_read(32'h00, 32'h0, OKAY, "rd_ctrl0");
        do_read(32'h04, 32'h0, OKAY, "rd_fg0");
        do_read(32'h08, 32'h0, OKAY, "rd_bg0");
        do_read(32'h0C, 32'h0, OKAY, "rd_stat0");

        // Simultaneous AW and W.
        do_write(32'h04, 32'h0000_0ABC, OKAY, "wr_fg");
        check_val("fg_out", 32'(fg_color_o), 32'h0ABC);
        do_read(32'h04, 32'h0000_0ABC, OKAY, "rd_fg");

        // W three cycles ahead of AW, then B back-pressured for four cycles.
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        check_val("hw.wready_low", 32'(wready), 32'd0);
        check_val("hw.awready_high", 32'(awready), 32'd1);
        repeat (2) @(negedge clk);
        awaddr = 32'h00; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("hw.bvalid_hold", 32'(bvalid), 32'd1);
            check_val("hw.bresp_hold", 32'(bresp), 32'(OKAY));
            check_val("hw.awready_held0", 32'(awready), 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check_val("hw.bvalid_drop", 32'(bvalid), 32'd0);
        check_val("hw.ctrl_en", 32'(ctrl_en_o), 32'd1);
        check_val("hw.ctrl_mode", 32'(ctrl_mode_o), 32'd3);
        do_read(32'h00, 32'h0000_0007, OKAY, "rd_ctrl");

        // Error cases leave the register file untouched.
        do_write(32'h0C, 32'h0000_0055, SLVERR, "wr_status");
        do_write(32'h10, 32'h0000_0123, SLVERR, "wr_unmapped");
        do_write(32'h02, 32'h0000_0456, SLVERR, "wr_unaligned");
        do_read(32'h14, 32'h0, SLVERR, "rd_unmapped");
        do_read(32'h06, 32'h0, SLVERR, "rd_unaligned");
        check_val("err.ctrl_en", 32'(ctrl_en_o), 32'd1);
        check_val("err.ctrl_mode", 32'(ctrl_mode_o), 32'd3);
        check_val("err.fg", 32'(fg_color_o), 32'h0ABC);
        check_val("err.bg", 32'(bg_color_o), 32'h000);
        do_read(32'h0C, 32'h0, OKAY, "rd_stat_err");

        // Frame counter wrap: 65537 increments from zero leaves 1.
        frame_done_i = 1'b1;
        repeat (65537) @(negedge clk);
        frame_done_i = 1'b0;
        do_read(32'h0C, 32'h0000_0001, OKAY, "rd_stat_wrap");

        // STATUS read coinciding with a pulse sees the old count.
        araddr = 32'h0C; arvalid = 1'b1; rready = 1'b1; frame_done_i = 1'b1;
        check_val("coinc.arready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0; frame_done_i = 1'b0;
        check_val("coinc.rdata", rdata, 32'h0000_0001);
        @(negedge clk);
        do_read(32'h0C, 32'h0000_0002, OKAY, "rd_stat_after");

        // Reset with a read awaiting rready and a write parked in HAVE_AW.
        araddr = 32'h00; arvalid = 1'b1; rready = 1'b0;
        awaddr = 32'h04; awvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0;
        check_val("mid.rvalid_pre", 32'(rvalid), 32'd1);
        check_val("mid.awready_pre", 32'(awready), 32'd0);
        #2;
        arst_n = 1'b0;
        #1;
        check_val("mid.rvalid", 32'(rvalid), 32'd0);
        check_val("mid.bvalid", 32'(bvalid), 32'd0);
        check_val("mid.ctrl_en", 32'(ctrl_en_o), 32'd0);
        check_val("mid.fg", 32'(fg_color_o), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        do_write(32'h08, 32'h0000_0123, OKAY, "post_wr_bg");
        check_val("post.bg", 32'(bg_color_o), 32'h0123);
        do_read(32'h08, 32'h0000_0123, OKAY, "post_rd_bg");
        do_read(32'h04, 32'h0, OKAY, "post_rd_fg");
        do_read(32'h0C, 32'h0, OKAY, "post_rd_stat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
